// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 16x oversampled, byte held with valid/read handshake, framing and overrun flags.
// Define RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote over ticks 16k+7..16k+9.
module uart_rx_deserializer #(
  parameter int CLK_DIV   = 54,
  parameter int DATA_BITS = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 SDI,
  input  logic                 DataRead,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxDataValid,
  output logic                 FramingError,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

`ifdef RX_MAJORITY_VOTE_EN
  localparam int HIST_W = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`else
  localparam int HIST_W = 1;
`endif

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [7:0]             tick_cnt_q, tick_cnt_d;
  logic [HIST_W-1:0]      hist_q, hist_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ok_q, ok_d, bad_q, bad_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d, ovr_q, ovr_d, fe_q, fe_d;
  logic                   rx_s, tick_s, decide_s, bit_s;

  assign rx_s     = sync2_q;
  assign tick_s   = (div_q == DIV_MAX);
  assign decide_s = tick_s && (tick_cnt_q[3:0] == 4'd8);

`ifdef RX_MAJORITY_VOTE_EN
  assign bit_s = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign bit_s = hist_q[0];
`endif

  // Frame sequencing: tick divider, tick counter, sample history and bit decisions.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    hist_d     = hist_q;
    shift_d    = shift_q;
    ok_d       = 1'b0;
    bad_d      = 1'b0;
    if (tick_s) begin
      div_d      = {DIV_W{1'b0}};
      tick_cnt_d = tick_cnt_q + 8'd1;
`ifdef RX_MAJORITY_VOTE_EN
      hist_d     = {hist_q[0], rx_s};
`else
      hist_d     = rx_s;
`endif
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        div_d = {DIV_W{1'b0}};
        if (!rx_s) begin
          state_d    = S_START;
          tick_cnt_d = 8'd0;
          shift_d    = {DATA_BITS{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (decide_s) begin
          state_d = bit_s ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (decide_s) begin
          shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
          state_d = (tick_cnt_q[7:4] == 4'(DATA_BITS)) ? S_STOP : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (decide_s) begin
          ok_d    = bit_s;
          bad_d   = !bit_s;
          state_d = bit_s ? S_IDLE : S_WAIT_HIGH;
        end else begin
          state_d = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        div_d   = {DIV_W{1'b0}};
        state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
      end
      default: begin
        state_d = S_IDLE;
        div_d   = {DIV_W{1'b0}};
      end
    endcase
  end

  // Output handshake: a byte load beats a coincident read and clears rather than sets overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = bad_q;
    if (ok_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && DataRead) begin
        ovr_d = 1'b0;
      end else if (valid_q) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end else if (valid_q && DataRead) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and datapath registers; synchronizer idles high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      div_q      <= {DIV_W{1'b0}};
      tick_cnt_q <= 8'd0;
      hist_q     <= {HIST_W{1'b1}};
      shift_q    <= {DATA_BITS{1'b0}};
      ok_q       <= 1'b0;
      bad_q      <= 1'b0;
      data_q     <= {DATA_BITS{1'b0}};
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= SDI;
      sync2_q    <= sync1_q;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      hist_q     <= hist_d;
      shift_q    <= shift_d;
      ok_q       <= ok_d;
      bad_q      <= bad_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
    end
  end

  assign RxData       = data_q;
  assign RxDataValid  = valid_q;
  assign Overrun      = ovr_q;
  assign FramingError = fe_q;
  assign Busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at CLK_DIV=4 (64 clocks per bit).
module tb_uart_rx_deserializer;

  logic       Clock, Reset, SDI, DataRead;
  logic [7:0] RxData;
  logic       RxDataValid, FramingError, Overrun, Busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_deserializer #(.CLK_DIV(4), .DATA_BITS(8)) dut (
    .Clock(Clock), .Reset(Reset), .SDI(SDI), .DataRead(DataRead),
    .RxData(RxData), .RxDataValid(RxDataValid), .FramingError(FramingError),
    .Overrun(Overrun), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    int         read_cyc;
    logic       post_read;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_fe_cyc;
    int         exp_rise;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Cycle c: sample outputs just after edge S+c, then drive frame cycle c.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch,
                            input int read_cyc, output int fe_cnt, output int fe_cyc,
                            output int rise_cyc);
    logic [9:0] bits;
    logic       prev_v;
    bits     = {stop, d, 1'b0};
    fe_cnt   = 0;
    fe_cyc   = -1;
    rise_cyc = -1;
    prev_v   = RxDataValid;
    for (int c = 0; c < 640; c++) begin
      @(posedge Clock); #1;
      if (FramingError) begin fe_cnt++; fe_cyc = c; end
      if (RxDataValid && !prev_v && rise_cyc < 0) rise_cyc = c;
      prev_v   = RxDataValid;
      SDI      = (glitch && c >= 285 && c <= 288) ? 1'b0 : bits[c/64];
      DataRead = (c == read_cyc);
    end
    @(posedge Clock); #1;
    SDI      = 1'b1;
    DataRead = 1'b0;
  endtask

  task automatic apply_row(input int i);
    int fe_cnt, fe_cyc, rise;
    send_frame(tbl[i].data, tbl[i].stop, tbl[i].glitch, tbl[i].read_cyc, fe_cnt, fe_cyc, rise);
    repeat (40) @(posedge Clock);
    #1;
    check($sformatf("row%0d RxData", i), int'(RxData), int'(tbl[i].exp_data));
    check($sformatf("row%0d RxDataValid", i), int'(RxDataValid), int'(tbl[i].exp_valid));
    check($sformatf("row%0d Overrun", i), int'(Overrun), int'(tbl[i].exp_ovr));
    check($sformatf("row%0d FE count", i), fe_cnt, (tbl[i].exp_fe_cyc < 0) ? 0 : 1);
    check($sformatf("row%0d FE cycle", i), fe_cyc, tbl[i].exp_fe_cyc);
    check($sformatf("row%0d valid rise", i), rise, tbl[i].exp_rise);
    check($sformatf("row%0d Busy", i), int'(Busy), 0);
    if (tbl[i].post_read) begin
      DataRead = 1'b1;
      @(posedge Clock); #1;
      DataRead = 1'b0;
      check($sformatf("row%0d valid after read", i), int'(RxDataValid), 0);
      check($sformatf("row%0d overrun after read", i), int'(Overrun), 0);
    end
  endtask

  initial begin
    logic [7:0] glitch_exp;
    logic [9:0] bits77;
`ifdef RX_MAJORITY_VOTE_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hF7;
`endif
    //          data   stop  glt   rd   prd   exp   v     ovr   fe   rise
    tbl[0] = '{8'h3C, 1'b1, 1'b0, -1,  1'b1, 8'h3C, 1'b1, 1'b0, -1,  616};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, -1,  1'b1, 8'hA5, 1'b1, 1'b0, -1,  616};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, -1,  1'b1, 8'hA5, 1'b0, 1'b0, 616, -1};
    tbl[3] = '{8'h11, 1'b1, 1'b0, -1,  1'b0, 8'h11, 1'b1, 1'b0, -1,  616};
    tbl[4] = '{8'h22, 1'b1, 1'b0, -1,  1'b1, 8'h22, 1'b1, 1'b1, -1,  -1};
    tbl[5] = '{8'h11, 1'b1, 1'b0, -1,  1'b0, 8'h11, 1'b1, 1'b0, -1,  616};
    tbl[6] = '{8'h22, 1'b1, 1'b0, 615, 1'b1, 8'h22, 1'b1, 1'b0, -1,  -1};
    tbl[7] = '{8'hC3, 1'b1, 1'b0, -1,  1'b0, 8'hC3, 1'b1, 1'b0, -1,  616};
    tbl[8] = '{8'h5A, 1'b1, 1'b0, -1,  1'b1, 8'h5A, 1'b1, 1'b0, -1,  616};
    tbl[9] = '{8'hFF, 1'b1, 1'b1, -1,  1'b0, glitch_exp, 1'b1, 1'b0, -1, 616};

    Reset    = 1'b0;
    SDI      = 1'b1;
    DataRead = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset RxData", int'(RxData), 0);
    check("reset RxDataValid", int'(RxDataValid), 0);
    check("reset FramingError", int'(FramingError), 0);
    check("reset Overrun", int'(Overrun), 0);
    check("reset Busy", int'(Busy), 0);
    Reset = 1'b1;
    repeat (10) @(posedge Clock);
    #1;

    // Start-bit glitch: 12 clocks low, rejected at tick 9 (edge S+39).
    for (int c = 0; c < 80; c++) begin
      @(posedge Clock); #1;
      if (c == 2)  check("glitch Busy before edge", int'(Busy), 0);
      if (c == 3)  check("glitch Busy after edge", int'(Busy), 1);
      if (c == 38) check("glitch Busy before tick9", int'(Busy), 1);
      if (c == 39) check("glitch Busy after tick9", int'(Busy), 0);
      SDI = (c < 12) ? 1'b0 : 1'b1;
    end
    check("glitch no valid", int'(RxDataValid), 0);
    check("glitch no FE", int'(FramingError), 0);

    for (int i = 0; i < 8; i++) apply_row(i);

    // Reset in the middle of data bit 4 of 0x77, with 0xC3 still unread.
    bits77 = {1'b1, 8'h77, 1'b0};
    for (int c = 0; c <= 350; c++) begin
      @(posedge Clock); #1;
      if (c == 350) begin
        check("pre-reset Busy", int'(Busy), 1);
        Reset = 1'b0;
        #1;
        check("midframe reset RxData", int'(RxData), 0);
        check("midframe reset RxDataValid", int'(RxDataValid), 0);
        check("midframe reset Overrun", int'(Overrun), 0);
        check("midframe reset FramingError", int'(FramingError), 0);
        check("midframe reset Busy", int'(Busy), 0);
      end else begin
        SDI = bits77[c/64];
      end
    end
    @(posedge Clock); #1;
    Reset = 1'b1;
    SDI   = 1'b1;
    repeat (100) @(posedge Clock);
    #1;
    check("post-reset idle Busy", int'(Busy), 0);

    for (int i = 8; i < 10; i++) apply_row(i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
